// File: rtl/riscv_crypto_sbox_seq.sv
// Sequential S-box substitution engine shared by two requesters.
// Ports: clk/reset; req_valid_i/req_ready_o and req{0,1}_{data,mode}_i
// accept a word; rsp_valid_o/rsp_ready_i/rsp_data_o return it; the
// sbox_x_o/sbox_mode_o/sbox_y_i triple drives an external combinational
// S-box one byte lane per cycle; busy_o flags any non-idle state.
module riscv_crypto_sbox_seq #(
    parameter int unsigned RR = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid_i,
    output logic [1:0]  req_ready_o,
    input  logic [31:0] req0_data_i,
    input  logic [31:0] req1_data_i,
    input  logic [1:0]  req0_mode_i,
    input  logic [1:0]  req1_mode_i,
    output logic [1:0]  rsp_valid_o,
    input  logic [1:0]  rsp_ready_i,
    output logic [31:0] rsp_data_o,
    output logic [7:0]  sbox_x_o,
    output logic [1:0]  sbox_mode_o,
    input  logic [7:0]  sbox_y_i,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e      state_q;
    logic [1:0]  cnt_q;
    logic        last_q;
    logic        owner_q;
    logic [31:0] data_q;
    logic [1:0]  mode_q;
    logic [31:0] res_q;

    logic [1:0]  grant;
    logic        accept;
    logic        sel;
    logic        bypass;
    logic        rsp_hs;
    logic [7:0]  lane_byte;

    // On a tie, round-robin hands the word to whoever did not win last.
    always_comb begin
        grant = 2'b00;
        case (req_valid_i)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (RR != 0 && !last_q) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    assign req_ready_o = (state_q == IDLE) ? grant : 2'b00;
    assign accept      = |req_ready_o;
    assign sel         = grant[1];

    assign lane_byte = data_q[{cnt_q, 3'b000} +: 8];
    assign bypass    = (mode_q == 2'b11);

    // Bypass words keep the shared S-box port quiet.
    assign sbox_x_o    = (state_q == RUN && !bypass) ? lane_byte : 8'h00;
    assign sbox_mode_o = (state_q == RUN && !bypass) ? mode_q : 2'b00;

    assign rsp_valid_o = (state_q == DONE) ? {owner_q, ~owner_q} : 2'b00;
    assign rsp_data_o  = res_q;
    assign busy_o      = (state_q != IDLE);
    assign rsp_hs      = (state_q == DONE) && rsp_ready_i[owner_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            data_q  <= 32'h0;
            mode_q  <= 2'b00;
            res_q   <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        data_q  <= sel ? req1_data_i : req0_data_i;
                        mode_q  <= sel ? req1_mode_i : req0_mode_i;
                        owner_q <= sel;
                        last_q  <= sel;
                        cnt_q   <= 2'd0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    res_q[{cnt_q, 3'b000} +: 8] <=
                        bypass ? lane_byte : sbox_y_i;
                    // Lane 3 wraps the counter back to 0.
                    cnt_q <= cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_hs) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/riscv_crypto_sbox_seq.md
RISCV_CRYPTO_SBOX_SEQ -- requirements
Module: riscv_crypto_sbox_seq

Interface
REQ-001 SHALL have parameter RR, default 1, arbitration: 1 = round-robin, 0 = fixed priority to requester 0.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port req_valid_i  input  2  per-requester word valid (bit0 = round datapath, bit1 = key schedule).
REQ-005 SHALL have port req_ready_o  output  2  per-requester accept, at most one bit set.
REQ-006 SHALL have ports req0_data_i / req1_data_i  input  32  word to substitute, byte lane 0 = bits 7:0.
REQ-007 SHALL have ports req0_mode_i / req1_mode_i  input  2  00 AES fwd, 01 AES inv, 10 SM4, 11 bypass.
REQ-008 SHALL have port rsp_valid_o  output  2  one-hot result valid, owner = accepted requester.
REQ-009 SHALL have port rsp_ready_i  input  2  per-requester result accept.
REQ-010 SHALL have port rsp_data_o  output  32  substituted word, qualified by rsp_valid_o.
REQ-011 SHALL have port sbox_x_o  output  8  byte to the shared combinational S-box.
REQ-012 SHALL have port sbox_mode_o  output  2  S-box mode select (encoding as REQ-007).
REQ-013 SHALL have port sbox_y_i  input  8  S-box result, same cycle as sbox_x_o (combinational path).
REQ-014 SHALL have port busy_o  output  1  high whenever state != IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; RUN uses 2-bit lane counter cnt.
REQ-016 In IDLE, grant SHALL be: one valid -> that requester; both valid, RR=1 -> requester not granted last; both valid, RR=0 -> requester 0.
REQ-017 req_ready_o[i] SHALL equal (state==IDLE) & grant[i]; never asserted in RUN or DONE.
REQ-018 On accept in cycle N: latch data, mode, owner; update last_grant; go RUN with cnt=0 in N+1.
REQ-019 In RUN, sbox_x_o SHALL be byte cnt of latched data, sbox_mode_o = latched mode; sbox_y_i captured into result byte cnt at cycle end.
REQ-020 RUN SHALL last exactly 4 cycles (N+1..N+4, lanes 0,1,2,3); cnt wraps 3->0 on RUN->DONE.
REQ-021 Mode 11: result byte = input byte; sbox_x_o = 8'h00 and sbox_mode_o = 00 during RUN; timing unchanged.
REQ-022 rsp_valid_o[owner] SHALL assert from N+5; rsp_data_o and rsp_valid_o SHALL stay stable until rsp_ready_i[owner].
REQ-023 On rsp handshake, SHALL return to IDLE next cycle; accept in the same cycle is not allowed (min 6 cycles per word).
REQ-024 rsp_ready_i of non-owner and req_valid_i changes during RUN/DONE SHALL be ignored.
REQ-025 Outside RUN, sbox_x_o = 8'h00 and sbox_mode_o = 2'b00.

Reset
REQ-026 reset SHALL force IDLE, cnt=0, last_grant=requester 1 (so requester 0 wins first tie), latched data/result=0.
REQ-027 Reset values SHALL be: req_ready_o per REQ-017 from IDLE, rsp_valid_o=0, rsp_data_o=0, sbox_x_o=0, sbox_mode_o=0, busy_o=0.
REQ-028 reset asserted in RUN or DONE SHALL abort the word with no rsp_valid_o pulse; reset takes priority over all handshakes.

Verification (bench drives sbox_y_i from a golden AES/AES^-1/SM4 S-box model)
REQ-029 req0 0x00000053 mode 00 -> req_ready_o=01 same cycle, rsp_valid_o=01 five cycles later, rsp_data_o=0x636363ED, sbox_x_o sequence 53,00,00,00.
REQ-030 req1 0x7C63637C mode 01 -> rsp_data_o=0x01000001 on rsp_valid_o=10; mode 10 with 0x00000000 -> 0xD6D6D6D6.
REQ-031 Both valid continuously, RR=1, rsp_ready_i=11 -> grants alternate 0,1,0,1 starting with 0, one accept every 6 cycles; RR=0 -> requester 1 never granted.
REQ-032 Hold rsp_ready_i=00 for 10 cycles in DONE, toggle req_valid_i and rsp_ready_i[non-owner] -> rsp_data_o stable, no new accept, busy_o=1.
REQ-033 Mode 11 word 0xDEADBEEF -> rsp_data_o=0xDEADBEEF, sbox_x_o=0 throughout.
REQ-034 reset asserted at RUN cnt=2 -> next cycle IDLE, busy_o=0, no rsp_valid_o; next tie grants requester 0.
